// File: rtl/button_event_ctrl.sv
`default_nettype none
// =============================================================================
// button_event_ctrl : shared-tick debouncer, press/auto-repeat event generator
//                     and round-robin valid/ready event arbiter.
// Revision: 1.0
// =============================================================================

module button_event_ctrl #(
  parameter int N_BTN     = 4,
  parameter int ID_W      = 2,
  parameter int TICK_BITS = 19,
  parameter int DB_TICKS  = 3,
  parameter int REP_DLY   = 50,
  parameter int REP_PER   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] sw,
  output logic [N_BTN-1:0] db,
  output logic             tick,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  output logic             evt_rep,
  input  logic             evt_ready
);

  localparam int c_DB_W    = $clog2(DB_TICKS + 1);
  localparam int c_REP_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int c_REP_W   = $clog2(c_REP_MAX + 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_OFFER = 1'b1} state_t;

  logic [TICK_BITS-1:0] r_tick_cnt;
  logic [N_BTN-1:0]     r_sync1;
  logic [N_BTN-1:0]     r_sync2;
  logic [N_BTN-1:0]     r_db;
  logic [N_BTN-1:0]     r_pend;
  logic [N_BTN-1:0]     r_pend_rep;
  logic [N_BTN-1:0]     w_db_flip;
  logic [N_BTN-1:0]     w_press;
  logic [N_BTN-1:0]     w_rep_fire;
  logic [N_BTN-1:0]     w_gnt_oh;
  logic [N_BTN-1:0]     w_clr;
  logic                 w_hi_found;
  logic [ID_W-1:0]      w_hi_id;
  logic [ID_W-1:0]      w_lo_id;
  logic [ID_W-1:0]      w_gnt_id;
  logic                 w_gnt_rep;
  state_t               r_state;
  logic                 r_evt_valid;
  logic [ID_W-1:0]      r_evt_id;
  logic                 r_evt_rep;
  logic [ID_W-1:0]      r_last_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_BITS'(1);
      r_sync1    <= sw;
      r_sync2    <= r_sync1;
    end
  end

  assign tick = &r_tick_cnt;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [c_DB_W-1:0] r_db_cnt;
    logic              w_disagree;

    assign w_disagree   = r_sync2[i] ^ r_db[i];
    assign w_db_flip[i] = tick & w_disagree & (r_db_cnt == c_DB_W'(DB_TICKS - 1));

    // Any cycle of agreement restarts the count, so bounces never accumulate.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        r_db_cnt <= '0;
      else if (!w_disagree || w_db_flip[i])
        r_db_cnt <= '0;
      else if (tick)
        r_db_cnt <= r_db_cnt + c_DB_W'(1);
    end

    if (REP_DLY != 0) begin : g_rep
      logic [c_REP_W-1:0] r_rep_cnt;
      logic               r_armed;
      logic               w_due;

      // r_armed selects the initial delay versus the steady repeat period.
      assign w_due = r_armed ? (r_rep_cnt == c_REP_W'(REP_PER - 1))
                             : (r_rep_cnt == c_REP_W'(REP_DLY - 1));
      assign w_rep_fire[i] = r_db[i] & tick & w_due;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_rep_cnt <= '0;
          r_armed   <= 1'b0;
        end else if (!r_db[i]) begin
          r_rep_cnt <= '0;
          r_armed   <= 1'b0;
        end else if (tick) begin
          if (w_due) begin
            r_rep_cnt <= '0;
            r_armed   <= 1'b1;
          end else begin
            r_rep_cnt <= r_rep_cnt + c_REP_W'(1);
          end
        end
      end
    end else begin : g_no_rep
      assign w_rep_fire[i] = 1'b0;
    end

    assign w_gnt_oh[i] = r_pend[i] & (w_gnt_id == ID_W'(i));
  end

  assign w_press = w_db_flip & ~r_db;
  assign w_clr   = (r_state == S_IDLE) ? w_gnt_oh : '0;

  // A new request in the grant cycle outranks the clear; a fresh press forces rep to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_db       <= '0;
      r_pend     <= '0;
      r_pend_rep <= '0;
    end else begin
      r_db       <= r_db ^ w_db_flip;
      r_pend     <= w_press | w_rep_fire | (r_pend & ~w_clr);
      r_pend_rep <= (w_rep_fire | (r_pend_rep & ~w_clr)) & ~w_press;
    end
  end

  assign db = r_db;

  always_comb begin
    w_hi_found = 1'b0;
    w_hi_id    = '0;
    w_lo_id    = '0;
    for (int j = N_BTN - 1; j >= 0; j--) begin
      if (r_pend[j]) begin
        w_lo_id = ID_W'(j);
        if (ID_W'(j) > r_last_grant) begin
          w_hi_found = 1'b1;
          w_hi_id    = ID_W'(j);
        end
      end
    end
    w_gnt_id = w_hi_found ? w_hi_id : w_lo_id;
  end

  assign w_gnt_rep = |(r_pend_rep & w_gnt_oh);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_evt_valid  <= 1'b0;
      r_evt_id     <= '0;
      r_evt_rep    <= 1'b0;
      r_last_grant <= ID_W'(N_BTN - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|r_pend) begin
            r_evt_id    <= w_gnt_id;
            r_evt_rep   <= w_gnt_rep;
            r_evt_valid <= 1'b1;
            r_state     <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (evt_ready) begin
            r_last_grant <= r_evt_id;
            r_evt_valid  <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_id    = r_evt_id;
  assign evt_rep   = r_evt_rep;

endmodule

`default_nettype wire

// File: tb/tb_button_event_ctrl.sv
`default_nettype none
// =============================================================================
// tb_button_event_ctrl : directed scenarios plus random stimulus against a
//                        cycle-level behavioural model of button_event_ctrl.
// Revision: 1.0
// =============================================================================

module tb_button_event_ctrl;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TB  = 4;
  localparam int P   = 16;
  localparam int DBT = 3;
  localparam int RD  = 4;
  localparam int RP  = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   sw = '0;
  logic [N-1:0]   db;
  logic           tick;
  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic           evt_rep;
  logic           evt_ready = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_event_ctrl #(
    .N_BTN(N), .ID_W(IDW), .TICK_BITS(TB), .DB_TICKS(DBT), .REP_DLY(RD), .REP_PER(RP)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .db(db), .tick(tick),
    .evt_valid(evt_valid), .evt_id(evt_id), .evt_rep(evt_rep), .evt_ready(evt_ready)
  );

  // Behavioural model: phase since reset, disagreement streaks, ticks held, pending table.
  int           m_phase;
  logic [N-1:0] m_s1, m_s2, m_db;
  int           m_dis [N];
  int           m_held[N];
  bit           m_pend[N];
  bit           m_prep[N];
  bit           m_valid;
  int           m_id;
  bit           m_rep;
  int           m_last;
  bit           m_tk;
  bit           m_press[N];
  bit           m_fire [N];
  bit           m_found;
  int           m_n;
  int           m_c;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_s1 = '0; m_s2 = '0; m_db = '0;
      m_valid = 1'b0; m_id = 0; m_rep = 1'b0; m_last = N - 1;
      for (int i = 0; i < N; i++) begin
        m_dis[i] = 0; m_held[i] = 0; m_pend[i] = 1'b0; m_prep[i] = 1'b0;
      end
    end else begin
      m_tk = (m_phase % P) == (P - 1);
      for (int i = 0; i < N; i++) begin
        m_press[i] = 1'b0;
        m_fire[i]  = 1'b0;
        if (m_db[i]) begin
          if (m_tk) begin
            m_n = m_held[i] + 1;
            m_fire[i] = (RD != 0) && ((m_n == RD) || (m_n > RD && ((m_n - RD) % RP) == 0));
            m_held[i] = m_n;
          end
        end else begin
          m_held[i] = 0;
        end
        if (m_s2[i] != m_db[i]) begin
          if (m_tk) m_dis[i] = m_dis[i] + 1;
          if (m_dis[i] == DBT) begin
            m_dis[i]   = 0;
            m_db[i]    = ~m_db[i];
            m_press[i] = m_db[i];
          end
        end else begin
          m_dis[i] = 0;
        end
      end
      if (m_valid) begin
        if (evt_ready) begin
          m_last  = m_id;
          m_valid = 1'b0;
        end
      end else begin
        m_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          m_c = (m_last + k) % N;
          if (!m_found && m_pend[m_c]) begin
            m_found    = 1'b1;
            m_id       = m_c;
            m_rep      = m_prep[m_c];
            m_valid    = 1'b1;
            m_pend[m_c] = 1'b0;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (m_press[i]) begin
          m_pend[i] = 1'b1;
          m_prep[i] = 1'b0;
        end else if (m_fire[i]) begin
          m_prep[i] = m_pend[i] ? (m_prep[i] | 1'b1) : 1'b1;
          m_pend[i] = 1'b1;
        end
      end
      m_s2 = m_s1;
      m_s1 = sw;
      m_phase = m_phase + 1;
    end
  end

  logic [8:0] act, exp;
  always @(negedge clk) begin
    if (!reset) begin
      act = {tick, db, evt_valid, evt_valid ? evt_id : 2'b00, evt_valid & evt_rep};
      exp = {((m_phase % P) == (P - 1)), m_db, m_valid,
             m_valid ? IDW'(m_id) : 2'b00, m_valid & m_rep};
      tests++;
      if (act !== exp) begin
        fails++;
        $display("FAIL model cyc=%0d: got tick/db/valid/id/rep=%b required %b", cyc, act, exp);
      end
    end
  end

  int ev_id[$];
  int ev_rep[$];
  int ev_cyc[$];
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      ev_id.push_back(int'(evt_id));
      ev_rep.push_back(int'(evt_rep));
      ev_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input int got, input int req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic check_rng(input string name, input int got, input int lo, input int hi);
    tests++;
    if (got < lo || got > hi) begin
      fails++;
      $display("FAIL %s: got %0d required %0d..%0d", name, got, lo, hi);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic step(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    ev_id.delete(); ev_rep.delete(); ev_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; sw = '0; evt_ready = 1'b0;
    step(3);
    reset = 1'b0;
    clear_log();
  endtask

  task automatic wait_db(input int ch, input logic lvl, input int budget, output int k);
    k = 0;
    while (db[ch] !== lvl && k < budget) begin
      step();
      k++;
    end
    if (db[ch] !== lvl) check("wait_db_timeout", 0, 1);
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (evt_valid !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    if (evt_valid !== 1'b1) check("wait_valid_timeout", 0, 1);
  endtask

  int k, r_cyc, f_cyc, bad, late, rate, rdy;

  initial begin
    step(3);
    check("rst_valid", int'(evt_valid), 0);
    check("rst_id", int'(evt_id), 0);
    check("rst_rep", int'(evt_rep), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_db", int'(db), 0);

    // Clean press on channel 1.
    do_reset();
    evt_ready = 1'b1; sw = 4'b0010;
    wait_db(1, 1'b1, 70, k);
    check_rng("press_latency", k, 35, 51);
    step(40);
    check("press_count", ev_id.size(), 1);
    check("press_id", qget(ev_id, 0), 1);
    check("press_rep", qget(ev_rep, 0), 0);

    // Bounce on channel 0, then settle high.
    do_reset();
    evt_ready = 1'b1; bad = 0;
    for (int t = 0; t < 100; t++) begin
      if (t % 5 == 0) sw[0] = ~sw[0];
      step();
      if (db[0] !== 1'b0) bad++;
    end
    check("bounce_db_low", bad, 0);
    check("bounce_no_event", ev_id.size(), 0);
    sw[0] = 1'b1;
    wait_db(0, 1'b1, 70, k);
    check_rng("bounce_latency", k, 35, 51);
    step(10);
    check("bounce_count", ev_id.size(), 1);
    check("bounce_rep", qget(ev_rep, 0), 0);

    // Auto-repeat on channel 2.
    do_reset();
    evt_ready = 1'b1; sw = 4'b0100;
    wait_db(2, 1'b1, 70, k);
    r_cyc = cyc;
    step(200 - k);
    sw = '0;
    wait_db(2, 1'b0, 70, k);
    f_cyc = cyc;
    step(60);
    check("rep_ev0_dt", qget(ev_cyc, 0) - r_cyc, 1);
    check("rep_ev0_rep", qget(ev_rep, 0), 0);
    check("rep_ev1_dt", qget(ev_cyc, 1) - r_cyc, 1 + RD * P);
    check("rep_ev1_rep", qget(ev_rep, 1), 1);
    check("rep_ev2_dt", qget(ev_cyc, 2) - r_cyc, 1 + (RD + RP) * P);
    check("rep_ev2_id", qget(ev_id, 2), 2);
    late = 0;
    foreach (ev_cyc[i]) if (ev_cyc[i] > f_cyc + 2) late++;
    check("rep_after_release", late, 0);

    // Round-robin under backpressure.
    do_reset();
    evt_ready = 1'b0; sw = 4'b1011;
    wait_valid(70);
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      step();
      if (evt_valid !== 1'b1 || evt_id !== 2'd0) bad++;
    end
    check("bp_hold", bad, 0);
    evt_ready = 1'b1;
    step(8);
    check("rr_count", ev_id.size(), 3);
    check("rr_first", qget(ev_id, 0), 0);
    check("rr_second", qget(ev_id, 1), 1);
    check("rr_third", qget(ev_id, 2), 3);
    check("rr_gap01", (qget(ev_cyc, 1) - qget(ev_cyc, 0)) >= 2, 1);
    check("rr_gap12", (qget(ev_cyc, 2) - qget(ev_cyc, 1)) >= 2, 1);

    // Coalescing: repeats while the press is still on offer merge into one.
    do_reset();
    evt_ready = 1'b0; sw = 4'b1000;
    step(220);
    sw = '0;
    wait_db(3, 1'b0, 70, k);
    step(5);
    evt_ready = 1'b1;
    step(10);
    check("coal_count", ev_id.size(), 2);
    check("coal_ev0_id", qget(ev_id, 0), 3);
    check("coal_ev0_rep", qget(ev_rep, 0), 0);
    check("coal_ev1_rep", qget(ev_rep, 1), 1);

    // Reset while an event is offered.
    do_reset();
    evt_ready = 1'b0; sw = 4'b0100;
    wait_valid(70);
    step(3);
    reset = 1'b1; sw = '0;
    #1;
    check("midrst_valid", int'(evt_valid), 0);
    check("midrst_id", int'(evt_id), 0);
    check("midrst_rep", int'(evt_rep), 0);
    check("midrst_db", int'(db), 0);
    step(3);
    reset = 1'b0; evt_ready = 1'b1;
    clear_log();
    step(150);
    check("midrst_no_event", ev_id.size(), 0);

    // Random stimulus; the model comparison runs every cycle.
    do_reset();
    rate = 2; rdy = 100;
    for (int t = 0; t < 4000; t++) begin
      if (t % 400 == 0) rate = $urandom_range(0, 4);
      if (t % 100 == 0) begin
        case ($urandom_range(0, 3))
          0: rdy = 100;
          1: rdy = 70;
          2: rdy = 20;
          default: rdy = 0;
        endcase
      end
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 199) < rate) sw[i] = ~sw[i];
      evt_ready = ($urandom_range(0, 99) < rdy);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
